// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count, flush,
// overflow/underflow pulses and almost-full/almost-empty flags.
// Optional macro FIFO_FWFT_EN: first-word-fall-through read (head word is
// presented combinationally); default build is a registered 1-cycle read.
// Thresholds: AF_THRESH in 1..DEPTH, AE_THRESH in 0..DEPTH-1.
module fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = (2**ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  write,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] re_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  Full,
  output logic                  Almost_Full,
  output logic                  Empty,
  output logic                  Almost_empty
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_THRESH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  rd_ok, wr_ok;

  // A read needs data present; a write at full is fine if a read frees a slot
  // on the same edge. A read at empty never borrows the simultaneous write.
  assign rd_ok = read & (cnt_q != '0);
  assign wr_ok = write & ((cnt_q != DEPTH_C) | rd_ok);

  assign count        = cnt_q;
  assign Full         = (cnt_q == DEPTH_C);
  assign Empty        = (cnt_q == '0);
  assign Almost_Full  = (cnt_q >= AF_C);
  assign Almost_empty = (cnt_q <= AE_C);

  // Storage write; contents survive reset and flush on purpose.
  always_ff @(posedge clk) begin
    if (reset && !flush && wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and rejection pulses; reset beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      overflow  <= write & ~wr_ok;
      underflow <= read & ~rd_ok;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is always on the output; undefined content while Empty.
  assign re_data = mem[rd_ptr];
`else
  // Registered read: output updates only on an accepted read, else holds.
  always_ff @(posedge clk) begin
    if (!reset)                re_data <= '0;
    else if (!flush && rd_ok)  re_data <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: table-driven directed checks of fifo_param (DEPTH=16,
// AF=14, AE=2) plus hand sequences for reset, flush/wrap and mid-stream reset.
module tb_fifo_param;
  logic       clk = 1'b0;
  logic       reset, flush, write, read;
  logic [7:0] wr_data, re_data;
  logic [4:0] count;
  logic       overflow, underflow, Full, Almost_Full, Empty, Almost_empty;

  int n_tot  = 0;
  int n_pass = 0;

  fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_data(wr_data), .write(write),
    .read(read), .re_data(re_data), .count(count), .overflow(overflow),
    .underflow(underflow), .Full(Full), .Almost_Full(Almost_Full),
    .Empty(Empty), .Almost_empty(Almost_empty));

  always #5 clk = ~clk;

  typedef struct {
    bit       wr;
    bit       rd;
    bit [7:0] wd;
    bit [7:0] e_rd;
    bit [4:0] e_cnt;
    bit       e_ovf;
    bit       e_udf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
  endtask

  // Expected {Full, Almost_Full, Empty, Almost_empty} for a given occupancy.
  function automatic logic [3:0] flags_for(input int c);
    return {c == 16, c >= 14, c == 0, c <= 2};
  endfunction

  function automatic vec_t mk(input bit wr, input bit rd, input bit [7:0] wd,
                              input bit [7:0] e_rd, input bit [4:0] e_cnt,
                              input bit e_ovf, input bit e_udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.wd = wd; v.e_rd = e_rd;
    v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_udf = e_udf;
    return v;
  endfunction

  task automatic step(input bit wr, input bit rd, input bit fl, input logic [7:0] wd);
    write = wr; read = rd; flush = fl; wr_data = wd;
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; read = 1'b0; write = 1'b1; wr_data = 8'h47;

    // Fill 00..0F, then a rejected write and an idle cycle.
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 0, 8'(i), 8'h00, 5'(i + 1), 0, 0));
    vecs.push_back(mk(1, 0, 8'hAA, 8'h00, 5'd16, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 8'h00, 5'd16, 0, 0));
    // Drain 00..0F, then a rejected read and an idle cycle.
    for (int i = 0; i < 16; i++) vecs.push_back(mk(0, 1, 8'h00, 8'(i), 5'(15 - i), 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 8'h0F, 5'd0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 8'h0F, 5'd0, 0, 0));
    // Refill 80..8F, write+read at full, then drain: 81..8F and 55 last.
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 0, 8'h80 + 8'(i), 8'h0F, 5'(i + 1), 0, 0));
    vecs.push_back(mk(1, 1, 8'h55, 8'h80, 5'd16, 0, 0));
    for (int i = 0; i < 15; i++) vecs.push_back(mk(0, 1, 8'h00, 8'h81 + 8'(i), 5'(15 - i), 0, 0));
    vecs.push_back(mk(0, 1, 8'h00, 8'h55, 5'd0, 0, 0));
    // Write+read at empty: read rejected, write kept; next read returns 33.
    vecs.push_back(mk(1, 1, 8'h33, 8'h55, 5'd1, 0, 1));
    vecs.push_back(mk(0, 1, 8'h00, 8'h33, 5'd0, 0, 0));

    // Reset held for two edges while writing.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 0, count, 5'd0);
    chk("rst_flags", 0, {Full, Almost_Full, Empty, Almost_empty}, 4'b0011);
    chk("rst_ovf", 0, overflow, 1'b0);
`ifndef FIFO_FWFT_EN
    chk("rst_re_data", 0, re_data, 8'h00);
`endif
    reset = 1'b1; write = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].rd, 1'b0, vecs[i].wd);
      chk("count", i, count, vecs[i].e_cnt);
      chk("flags", i, {Full, Almost_Full, Empty, Almost_empty}, flags_for(int'(vecs[i].e_cnt)));
      chk("overflow", i, overflow, vecs[i].e_ovf);
      chk("underflow", i, underflow, vecs[i].e_udf);
`ifndef FIFO_FWFT_EN
      chk("re_data", i, re_data, vecs[i].e_rd);
`endif
    end

    // Flush after the write pointer has wrapped.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 8'hA0 + 8'(i));
    chk("fw_fill10", 0, count, 5'd10);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h00);
    chk("fw_drain10", 0, count, 5'd0);
`ifndef FIFO_FWFT_EN
    chk("fw_last_rd", 0, re_data, 8'hA9);
`endif
    for (int i = 0; i < 10; i++) step(1, 0, 0, 8'hB0 + 8'(i));
    chk("fw_wrap10", 0, count, 5'd10);
    step(1, 1, 1, 8'hEE);
    chk("flush_count", 0, count, 5'd0);
    chk("flush_flags", 0, {Full, Almost_Full, Empty, Almost_empty}, 4'b0011);
    chk("flush_pulses", 0, {overflow, underflow}, 2'b00);
`ifndef FIFO_FWFT_EN
    chk("flush_hold", 0, re_data, 8'hA9);
`endif
    step(1, 0, 0, 8'h77);
    chk("post_flush_cnt", 0, count, 5'd1);
`ifdef FIFO_FWFT_EN
    chk("fwft_head", 0, re_data, 8'h77);
`endif
    step(0, 1, 0, 8'h00);
    chk("post_flush_rdcnt", 0, count, 5'd0);
    chk("post_flush_udf", 0, underflow, 1'b0);
`ifndef FIFO_FWFT_EN
    chk("post_flush_rd", 0, re_data, 8'h77);
`endif

    // Reset mid-stream discards contents.
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h22);
    chk("pre_rst_cnt", 0, count, 5'd2);
    reset = 1'b0;
    step(1, 1, 0, 8'h99);
    reset = 1'b1;
    chk("mid_rst_cnt", 0, count, 5'd0);
    chk("mid_rst_flags", 0, {Full, Almost_Full, Empty, Almost_empty}, 4'b0011);
    chk("mid_rst_pulses", 0, {overflow, underflow}, 2'b00);
`ifndef FIFO_FWFT_EN
    chk("mid_rst_rd", 0, re_data, 8'h00);
`endif
    step(0, 1, 0, 8'h00);
    chk("mid_rst_udf", 0, underflow, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
